// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding-select encodings, default sizes and the pipeline tag type
package hazard_pkg;
  localparam int AW_DEF = 3;
  localparam int NREG_DEF = 8;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  typedef struct packed {
    logic v;
    logic [AW_DEF-1:0] rd;
  } tag_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the youngest in-flight producer of rs, regfile for r0
module fwd_select
  import hazard_pkg::*;
(
  input  tag_t              ex_tag,
  input  tag_t              mem_tag,
  input  logic [AW_DEF-1:0] rs,
  output logic [1:0]        sel
);
  always_comb
    sel = (rs == '0) ? FWD_RF :
          (ex_tag.v && ex_tag.rd == rs) ? FWD_EXMEM :
          (mem_tag.v && mem_tag.rd == rs) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID/EX issue control with countdown scoreboard; HAZ_PERF_EN adds stall_cnt
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW = AW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int ALU_LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic [AW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_is_load,
  input  logic          br_flush,
  input  logic          mem_busy,
  output logic          stall,
  output logic          issue,
  output logic [1:0]    ex_fwd_sel1,
  output logic [1:0]    ex_fwd_sel2
`ifdef HAZ_PERF_EN
  , output logic [15:0] stall_cnt
`endif
);
  logic [1:0] cnt [NREG];
  tag_t ex_tag, mem_tag;
  logic hit1, hit2, wen;
  logic [1:0] sel1, sel2, lat;
  always_comb begin
    hit1 = (id_rs1 != '0) && (cnt[id_rs1] != 2'd0);
    hit2 = (id_rs2 != '0) && (cnt[id_rs2] != 2'd0);
    stall = mem_busy | (id_valid & ~br_flush & (hit1 | hit2));
    issue = id_valid & ~br_flush & ~stall;
    wen = issue & id_regwrite & (id_rd != '0);
    lat = id_is_load ? 2'(LOAD_LAT) : 2'(ALU_LAT);
  end
  fwd_select u_sel1 (.ex_tag(ex_tag), .mem_tag(mem_tag), .rs(id_rs1), .sel(sel1));
  fwd_select u_sel2 (.ex_tag(ex_tag), .mem_tag(mem_tag), .rs(id_rs2), .sel(sel2));
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
      ex_tag <= '0;
      mem_tag <= '0;
      ex_fwd_sel1 <= FWD_RF;
      ex_fwd_sel2 <= FWD_RF;
    end else if (!mem_busy) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= (wen && id_rd == AW'(r)) ? lat : (cnt[r] != 2'd0) ? cnt[r] - 2'd1 : cnt[r];
      mem_tag <= ex_tag;
      ex_tag <= '{v: wen, rd: id_rd};
      ex_fwd_sel1 <= issue ? sel1 : FWD_RF;
      ex_fwd_sel2 <= issue ? sel2 : FWD_RF;
    end
  end
`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (id_valid && stall && !mem_busy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule
